// File: rtl/uart.sv
// ---------------------------------------------------------------------------
// uart -- 8N1 serial transmitter/receiver sharing one oversampling divider.
//
// A free-running divider produces one oversample tick every CLOCK_DIVIDE clks
// (CLOCK_RATE / (BAUD_RATE * PRESCALER), floored, never below 1). The receiver
// samples the synchronised rx line on those ticks, aiming at the middle of
// each bit. The transmitter times its bits with its own clk counter so every
// bit lasts exactly PRESCALER * CLOCK_DIVIDE clks, whatever the divider phase
// was when the frame started. Receiver and transmitter are independent.
//
// Optional feature (macro UART_RX_ERROR_EN):
//   defined   -> start-bit glitches and bad stop bits pulse rx_error; after a
//                bad stop bit the receiver waits for one full bit time of
//                idle-high line before it looks for a new start bit.
//   undefined -> rx_error is tied low, the stop bit is not checked, and a
//                start-bit glitch silently returns the receiver to idle.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-low reset
//   rx              in   serial receive line (idle high, asynchronous)
//   tx              out  serial transmit line (idle high, registered)
//   transmit        in   level request to send tx_byte
//   tx_byte         in   byte to send, captured when a frame starts
//   received        out  one-clk pulse, rx_byte holds a new byte
//   rx_byte         out  last good received byte
//   is_receiving    out  receiver is not idle
//   is_transmitting out  transmitter is not idle
//   rx_error        out  one-clk pulse on a receive fault
// ---------------------------------------------------------------------------
module uart #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PRESCALER  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       rx_error
);

    localparam int DIVIDE_RAW     = CLOCK_RATE / (BAUD_RATE * PRESCALER);
    localparam int CLOCK_DIVIDE   = (DIVIDE_RAW < 1) ? 1 : DIVIDE_RAW;
    localparam int BIT_CLKS       = PRESCALER * CLOCK_DIVIDE;
    localparam int HALF_TICKS     = (PRESCALER / 2 < 1) ? 1 : PRESCALER / 2;

    localparam int DIV_W  = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam int TICK_W = $clog2(PRESCALER + 1);
    localparam int BIT_W  = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [TICK_W-1:0] TICK_FULL  = TICK_W'(PRESCALER);
    localparam logic [TICK_W-1:0] TICK_HALF  = TICK_W'(HALF_TICKS);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BIT_CLKS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);

    // -----------------------------------------------------------------------
    // Oversample divider
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_count_reg;
    logic             tick;

    assign tick = (div_count_reg == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_count_reg <= '0;
        end else if (tick) begin
            div_count_reg <= '0;
        end else begin
            div_count_reg <= div_count_reg + DIV_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // rx synchroniser; both flops reset to the idle level so reset release
    // never looks like a start bit.
    // -----------------------------------------------------------------------
    logic rx_meta_reg;
    logic rx_sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Receiver
    // rx_count_reg counts oversample ticks down to the next sample point;
    // a sample is taken on the tick where it reads 1.
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_CHECK_START,
        RX_READ_BITS,
`ifdef UART_RX_ERROR_EN
        RX_ERROR_WAIT,
`endif
        RX_CHECK_STOP
    } rx_state_t;

    rx_state_t         rx_state_reg;
    logic [TICK_W-1:0] rx_count_reg;
    logic [2:0]        rx_bit_reg;
    logic [7:0]        rx_shift_reg;
    logic [7:0]        rx_byte_reg;
    logic              received_reg;
    logic              is_receiving_reg;
`ifdef UART_RX_ERROR_EN
    logic              rx_error_reg;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_reg     <= RX_IDLE;
            rx_count_reg     <= '0;
            rx_bit_reg       <= '0;
            rx_shift_reg     <= '0;
            rx_byte_reg      <= '0;
            received_reg     <= 1'b0;
            is_receiving_reg <= 1'b0;
`ifdef UART_RX_ERROR_EN
            rx_error_reg     <= 1'b0;
`endif
        end else begin
            received_reg <= 1'b0;
`ifdef UART_RX_ERROR_EN
            rx_error_reg <= 1'b0;
`endif
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_sync_reg) begin
                        rx_state_reg     <= RX_CHECK_START;
                        rx_count_reg     <= TICK_HALF;
                        is_receiving_reg <= 1'b1;
                    end
                end

                RX_CHECK_START: begin
                    if (tick) begin
                        if (rx_count_reg == TICK_ONE) begin
                            if (!rx_sync_reg) begin
                                rx_state_reg <= RX_READ_BITS;
                                rx_count_reg <= TICK_FULL;
                                rx_bit_reg   <= '0;
                            end else begin
                                // Line went back high before mid-bit: a glitch.
                                rx_state_reg     <= RX_IDLE;
                                is_receiving_reg <= 1'b0;
`ifdef UART_RX_ERROR_EN
                                rx_error_reg     <= 1'b1;
`endif
                            end
                        end else begin
                            rx_count_reg <= rx_count_reg - TICK_ONE;
                        end
                    end
                end

                RX_READ_BITS: begin
                    if (tick) begin
                        if (rx_count_reg == TICK_ONE) begin
                            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                            rx_count_reg <= TICK_FULL;
                            if (rx_bit_reg == 3'd7) begin
                                rx_state_reg <= RX_CHECK_STOP;
                            end else begin
                                rx_bit_reg <= rx_bit_reg + 3'd1;
                            end
                        end else begin
                            rx_count_reg <= rx_count_reg - TICK_ONE;
                        end
                    end
                end

                RX_CHECK_STOP: begin
                    if (tick) begin
                        if (rx_count_reg == TICK_ONE) begin
`ifdef UART_RX_ERROR_EN
                            if (rx_sync_reg) begin
                                rx_byte_reg      <= rx_shift_reg;
                                received_reg     <= 1'b1;
                                rx_state_reg     <= RX_IDLE;
                                is_receiving_reg <= 1'b0;
                            end else begin
                                // Framing error: keep the previous rx_byte.
                                rx_error_reg <= 1'b1;
                                rx_state_reg <= RX_ERROR_WAIT;
                                rx_count_reg <= TICK_FULL;
                            end
`else
                            rx_byte_reg      <= rx_shift_reg;
                            received_reg     <= 1'b1;
                            rx_state_reg     <= RX_IDLE;
                            is_receiving_reg <= 1'b0;
`endif
                        end else begin
                            rx_count_reg <= rx_count_reg - TICK_ONE;
                        end
                    end
                end

`ifdef UART_RX_ERROR_EN
                RX_ERROR_WAIT: begin
                    // Any low level restarts the one-bit idle qualification.
                    if (!rx_sync_reg) begin
                        rx_count_reg <= TICK_FULL;
                    end else if (tick) begin
                        if (rx_count_reg == TICK_ONE) begin
                            rx_state_reg     <= RX_IDLE;
                            is_receiving_reg <= 1'b0;
                        end else begin
                            rx_count_reg <= rx_count_reg - TICK_ONE;
                        end
                    end
                end
`endif

                default: begin
                    rx_state_reg     <= RX_IDLE;
                    is_receiving_reg <= 1'b0;
                end
            endcase
        end
    end

    assign received     = received_reg;
    assign rx_byte      = rx_byte_reg;
    assign is_receiving = is_receiving_reg;
`ifdef UART_RX_ERROR_EN
    assign rx_error     = rx_error_reg;
`else
    assign rx_error     = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Transmitter
    // tx_count_reg counts clks down to the end of the current bit so each bit
    // is exactly BIT_CLKS long independent of the oversample divider phase.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t        tx_state_reg;
    logic [BIT_W-1:0] tx_count_reg;
    logic [2:0]       tx_bit_reg;
    logic [7:0]       tx_shift_reg;
    logic             tx_reg;
    logic             is_transmitting_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_reg        <= TX_IDLE;
            tx_count_reg        <= '0;
            tx_bit_reg          <= '0;
            tx_shift_reg        <= '0;
            tx_reg              <= 1'b1;
            is_transmitting_reg <= 1'b0;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (transmit) begin
                        tx_shift_reg        <= tx_byte;
                        tx_state_reg        <= TX_START;
                        tx_count_reg        <= BIT_LAST;
                        tx_reg              <= 1'b0;
                        is_transmitting_reg <= 1'b1;
                    end
                end

                TX_START: begin
                    if (tx_count_reg == '0) begin
                        tx_state_reg <= TX_DATA;
                        tx_count_reg <= BIT_LAST;
                        tx_bit_reg   <= '0;
                        tx_reg       <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                    end else begin
                        tx_count_reg <= tx_count_reg - BIT_ONE;
                    end
                end

                TX_DATA: begin
                    if (tx_count_reg == '0) begin
                        tx_count_reg <= BIT_LAST;
                        if (tx_bit_reg == 3'd7) begin
                            tx_state_reg <= TX_STOP;
                            tx_reg       <= 1'b1;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                            tx_reg       <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        end
                    end else begin
                        tx_count_reg <= tx_count_reg - BIT_ONE;
                    end
                end

                TX_STOP: begin
                    if (tx_count_reg == '0) begin
                        // A request still pending chains the next frame with
                        // no idle gap after the stop bit.
                        if (transmit) begin
                            tx_shift_reg <= tx_byte;
                            tx_state_reg <= TX_START;
                            tx_count_reg <= BIT_LAST;
                            tx_reg       <= 1'b0;
                        end else begin
                            tx_state_reg        <= TX_IDLE;
                            is_transmitting_reg <= 1'b0;
                        end
                    end else begin
                        tx_count_reg <= tx_count_reg - BIT_ONE;
                    end
                end

                default: begin
                    tx_state_reg        <= TX_IDLE;
                    tx_reg              <= 1'b1;
                    is_transmitting_reg <= 1'b0;
                end
            endcase
        end
    end

    assign tx              = tx_reg;
    assign is_transmitting = is_transmitting_reg;

endmodule

// File: tb/tb_uart.sv
// ---------------------------------------------------------------------------
// tb_uart -- randomized scoreboard bench for uart (CLOCK_RATE=768000,
// BAUD_RATE=9600, PRESCALER=8 -> 80 clks per bit).
// Stimulus tasks push expected frames into queues; independent monitors pop
// and compare whenever the DUT shows a received/rx_error pulse or starts a
// frame on tx. Expectations follow UART_RX_ERROR_EN when it is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart;

    localparam int BIT = 80;
`ifdef UART_RX_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       is_transmitting;
    logic       rx_error;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] last_good = 8'h00;

    uart #(
        .CLOCK_RATE(768000),
        .BAUD_RATE (9600),
        .PRESCALER (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx),
        .tx             (tx),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .received       (received),
        .rx_byte        (rx_byte),
        .is_receiving   (is_receiving),
        .is_transmitting(is_transmitting),
        .rx_error       (rx_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- receive side stimulus ----------------
    // Drives one frame on rx. A bad stop bit is held low for 60 clks so the
    // mid-bit sample sees it, then the line returns high.
    task automatic rx_frame(input logic [7:0] d, input bit bad_stop);
        rx_exp_t    e;
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        if (bad_stop && ERR_EN) begin
            e.is_err = 1'b1;
            e.data   = 8'h00;
        end else begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end
        rx_q.push_back(e);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) check("is_receiving_mid_frame", int'(is_receiving), 1);
            if (k == 9 && bad_stop) begin
                rx = 1'b0;
                repeat (60) @(negedge clk);
                rx = 1'b1;
                repeat (20) @(negedge clk);
            end else begin
                rx = bits[k];
                repeat (BIT) @(negedge clk);
            end
        end
        if (bad_stop && ERR_EN) begin
            repeat (100) @(negedge clk);
            check("rx_byte_held_after_error", int'(rx_byte), int'(last_good));
        end
    endtask

    task automatic rx_glitch();
        rx_exp_t e;
        if (ERR_EN) begin
            e.is_err = 1'b1;
            e.data   = 8'h00;
            rx_q.push_back(e);
        end
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("is_receiving_idle_after_glitch", int'(is_receiving), 0);
    endtask

    // ---------------- transmit side stimulus ----------------
    // One frame: transmit held 160 clks, tx_byte scrambled mid-frame.
    task automatic tx_single(input logic [7:0] a);
        int hi;
        hi = 0;
        tx_byte  = a;
        transmit = 1'b1;
        tx_q.push_back(a);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (n == 100) tx_byte = 8'($urandom);
            if (n == 160) transmit = 1'b0;
            if (is_transmitting) hi++;
        end
        check("tx_busy_clks_single", hi, 10 * BIT);
        check("tx_idle_after_single", int'(is_transmitting), 0);
    endtask

    // Two chained frames: transmit still high when the first stop bit ends.
    task automatic tx_double(input logic [7:0] a, input logic [7:0] b);
        int hi;
        hi = 0;
        tx_byte  = a;
        transmit = 1'b1;
        tx_q.push_back(a);
        tx_q.push_back(b);
        for (int n = 0; n < 1800; n++) begin
            @(negedge clk);
            if (n == 100) tx_byte = b;
            if (n == 850) transmit = 1'b0;
            if (is_transmitting) hi++;
        end
        check("tx_busy_clks_double", hi, 20 * BIT);
        check("tx_idle_after_double", int'(is_transmitting), 0);
    endtask

    // ---------------- receive monitor ----------------
    initial begin : rx_mon
        rx_exp_t e;
        forever begin
            @(negedge clk);
            if (received || rx_error) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected_pulse actual=received:%0b,rx_error:%0b required=none",
                             received, rx_error);
                end else begin
                    e = rx_q.pop_front();
                    if (e.is_err) begin
                        check("rx_error_pulse", int'({received, rx_error}), 1);
                        $display("rx event: error");
                    end else begin
                        check("rx_received_pulse", int'({received, rx_error}), 2);
                        check("rx_byte", int'(rx_byte), int'(e.data));
                        $display("rx frame byte=%02h", rx_byte);
                    end
                end
            end
        end
    end

    // ---------------- transmit monitor ----------------
    initial begin : tx_mon
        logic       prev;
        logic [9:0] bits;
        logic [7:0] e;
        bit         bad;
        bit         aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
            end else if (prev && !tx) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected_frame actual=start_bit required=idle_line");
                    e = 8'h00;
                end else begin
                    e = tx_q.pop_front();
                end
                bits    = {1'b1, e, 1'b0};
                aborted = 1'b0;
                bad     = 1'b0;
                for (int n = 0; n < 10 * BIT; n++) begin
                    if (n > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (n % BIT == 0) bad = 1'b0;
                    if (tx !== bits[n / BIT] || is_transmitting !== 1'b1) bad = 1'b1;
                    if (n % BIT == BIT - 1) begin
                        checks++;
                        if (bad) begin
                            failures++;
                            $display("FAIL tx_bit%0d byte=%02h actual=level_or_busy_wrong required=level_%0b_busy_for_%0d_clks",
                                     n / BIT, e, bits[n / BIT], BIT);
                        end
                    end
                end
                if (aborted) begin
                    $display("tx frame byte=%02h aborted by reset", e);
                    prev = 1'b1;
                end else begin
                    $display("tx frame byte=%02h", e);
                    prev = tx;
                end
            end else begin
                prev = tx;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #(600_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] d;
        logic       quiet;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_received", int'(received), 0);
        check("reset_rx_byte", int'(rx_byte), 0);
        check("reset_is_receiving", int'(is_receiving), 0);
        check("reset_is_transmitting", int'(is_transmitting), 0);
        check("reset_rx_error", int'(rx_error), 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Receive: fixed 0xAA then random bytes with random gaps
        rx_frame(8'hAA, 1'b0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            rx_frame(d, 1'b0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end

        // Transmit: fixed 0xAA, random single, random chained pair
        repeat ($urandom_range(0, 9)) @(negedge clk);
        tx_single(8'hAA);
        repeat ($urandom_range(0, 9)) @(negedge clk);
        tx_single(8'($urandom));
        repeat ($urandom_range(0, 9)) @(negedge clk);
        tx_double(8'($urandom), 8'($urandom));

        // Bad stop bit, then a good frame
        rx_frame(8'h3C, 1'b1);
        rx_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check("rx_byte_after_recovery", int'(rx_byte), 8'h55);

        // Start-bit glitch
        rx_glitch();

        // Concurrent transmit and receive, fixed then random
        fork
            tx_single(8'h81);
            begin
                repeat ($urandom_range(0, 15)) @(negedge clk);
                rx_frame(8'h7E, 1'b0);
            end
        join
        check("rx_byte_concurrent", int'(rx_byte), 8'h7E);
        for (int i = 0; i < 2; i++) begin
            fork
                tx_single(8'($urandom));
                begin
                    repeat ($urandom_range(0, 15)) @(negedge clk);
                    rx_frame(8'($urandom), 1'b0);
                end
            join
        end

        // Reset in the middle of a 0x0F transmit
        repeat (10) @(negedge clk);
        tx_byte  = 8'h0F;
        transmit = 1'b1;
        tx_q.push_back(8'h0F);
        repeat (160) @(negedge clk);
        transmit = 1'b0;
        repeat (140) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midframe_reset_tx", int'(tx), 1);
        check("midframe_reset_is_transmitting", int'(is_transmitting), 0);
        check("midframe_reset_rx_byte", int'(rx_byte), 0);
        check("midframe_reset_received", int'(received), 0);
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        quiet = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || is_transmitting !== 1'b0 || is_receiving !== 1'b0) quiet = 1'b0;
        end
        check("post_reset_quiet", int'(quiet), 1);

        repeat (50) @(negedge clk);
        check("rx_queue_drained", rx_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
